// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg -- shared definitions for the UART word loader.
//   * loader_state_t : FSM state encoding of uart_word_loader
//   * DEF_*          : default parameter values for the loader and packer
//   * PAD_BYTE       : fill value for byte lanes of a partial (flushed) word
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PACK  = 3'd1,
        WRITE = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } loader_state_t;

    localparam int         DEF_ADDR_WIDTH = 10;
    localparam int         DEF_BASE_ADDR  = 0;
    localparam bit         DEF_MSB_FIRST  = 1'b1;
    localparam logic [7:0] PAD_BYTE       = 8'h00;

endpackage

// File: rtl/uart_word_packer.sv
// uart_word_packer -- assembles up to four bytes into a 32-bit word.
//
// Ports:
//   i_clk_uart : clock, rising edge
//   i_rst      : asynchronous active-high reset
//   i_byte     : byte to store
//   i_wr       : store i_byte into the next free lane
//   i_clr      : restart the word (all lanes to PAD_BYTE, count to 0);
//                with i_wr also high the byte lands in lane 0 of the new word
//   o_word     : packed word (registered lanes)
//   o_count    : number of bytes held, 0..4
//
// Parameter MSB_FIRST selects whether byte 0 sits in bits [31:24] (1) or [7:0] (0).
module uart_word_packer
    import uart_loader_pkg::*;
#(
    parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic        i_clk_uart,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_wr,
    input  logic        i_clr,
    output logic [31:0] o_word,
    output logic [2:0]  o_count
);

    logic [2:0] count_reg;

    always_ff @(posedge i_clk_uart or posedge i_rst) begin
        if (i_rst) begin
            count_reg <= 3'd0;
        end else if (i_clr) begin
            count_reg <= i_wr ? 3'd1 : 3'd0;
        end else if (i_wr) begin
            count_reg <= count_reg + 3'd1;
        end
    end

    // Byte index gi maps to physical lane LANE depending on byte order.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam int LANE = MSB_FIRST ? (3 - gi) : gi;
            logic [7:0] lane_reg;

            always_ff @(posedge i_clk_uart or posedge i_rst) begin
                if (i_rst) begin
                    lane_reg <= 8'h00;
                end else if (i_clr) begin
                    lane_reg <= (i_wr && (gi == 0)) ? i_byte : PAD_BYTE;
                end else if (i_wr && (count_reg == 3'(gi))) begin
                    lane_reg <= i_byte;
                end
            end

            assign o_word[LANE*8 +: 8] = lane_reg;
        end
    endgenerate

    assign o_count = count_reg;

endmodule

// File: rtl/uart_word_loader.sv
// uart_word_loader -- turns a UART byte stream into 32-bit memory writes.
//
// Ports:
//   i_clk_uart   : sole clock, rising edge
//   i_rst        : asynchronous active-high reset
//   i_data       : received byte
//   i_valid      : byte-valid level (a byte is taken on its rising edge)
//   i_clear_sign : receiver idle timeout, ends the load session
//   i_wr_ready   : memory accepts the write this cycle
//   o_wr_valid   : write request
//   o_wr_addr    : word address
//   o_wr_data    : word data
//   o_load_done  : one-cycle pulse at session end
//   o_word_count : words written in the current/last session
//   o_overrun    : sticky, a byte was lost
//   o_addr_wrap  : sticky, the write address wrapped
//   o_checksum   : XOR of the bytes kept in the session
//                  (present only when LOADER_CHECKSUM_EN is defined)
//
// Build option: define LOADER_CHECKSUM_EN to add o_checksum.
module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BASE_ADDR  = DEF_BASE_ADDR,
    parameter bit MSB_FIRST  = DEF_MSB_FIRST
) (
    input  logic                  i_clk_uart,
    input  logic                  i_rst,
    input  logic [7:0]            i_data,
    input  logic                  i_valid,
    input  logic                  i_clear_sign,
    input  logic                  i_wr_ready,
    output logic                  o_wr_valid,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [31:0]           o_wr_data,
    output logic                  o_load_done,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_overrun,
    output logic                  o_addr_wrap
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]            o_checksum
`endif
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    loader_state_t           state_reg;
    logic                    valid_prev_reg;
    logic                    wr_valid_reg;
    logic [ADDR_WIDTH-1:0]   wr_addr_reg;
    logic [ADDR_WIDTH:0]     word_count_reg;
    logic                    load_done_reg;
    logic                    overrun_reg;
    logic                    addr_wrap_reg;
    logic                    clear_pend_reg;
    logic                    skid_full_reg;
    logic [7:0]              skid_reg;

    logic                    accept;
    logic                    handshake;
    logic                    byte_taken;
    logic                    pk_wr;
    logic                    pk_clr;
    logic [7:0]              pk_byte;
    logic [31:0]             pk_word;
    logic [2:0]              pk_count;

    assign accept    = i_valid && !valid_prev_reg;
    assign handshake = wr_valid_reg && i_wr_ready;

    // Packer control and byte disposition. A byte is kept unless it arrives
    // while the skid register is already occupied, or outside IDLE/PACK/WRITE
    // (FLUSH and DONE have nowhere to put it).
    always_comb begin
        pk_wr      = 1'b0;
        pk_clr     = 1'b0;
        pk_byte    = i_data;
        byte_taken = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    pk_clr     = 1'b1;
                    pk_wr      = 1'b1;
                    byte_taken = 1'b1;
                end
            end
            PACK: begin
                if (accept) begin
                    pk_wr      = 1'b1;
                    byte_taken = 1'b1;
                end
            end
            WRITE: begin
                byte_taken = accept && !skid_full_reg;
                if (handshake) begin
                    pk_clr = 1'b1;
                    if (skid_full_reg) begin
                        // Skid byte becomes byte 0 of the next word.
                        pk_wr   = 1'b1;
                        pk_byte = skid_reg;
                    end else if (accept) begin
                        pk_wr = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (handshake) begin
                    pk_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    uart_word_packer #(
        .MSB_FIRST (MSB_FIRST)
    ) u_packer (
        .i_clk_uart (i_clk_uart),
        .i_rst      (i_rst),
        .i_byte     (pk_byte),
        .i_wr       (pk_wr),
        .i_clr      (pk_clr),
        .o_word     (pk_word),
        .o_count    (pk_count)
    );

    always_ff @(posedge i_clk_uart or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            valid_prev_reg <= 1'b0;
            wr_valid_reg   <= 1'b0;
            wr_addr_reg    <= BASE;
            word_count_reg <= '0;
            load_done_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            addr_wrap_reg  <= 1'b0;
            clear_pend_reg <= 1'b0;
            skid_full_reg  <= 1'b0;
            skid_reg       <= 8'h00;
        end else begin
            valid_prev_reg <= i_valid;
            if (accept && !byte_taken) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    load_done_reg <= 1'b0;
                    if (accept) begin
                        // First byte of a session restarts count and address.
                        word_count_reg <= '0;
                        wr_addr_reg    <= BASE;
                        clear_pend_reg <= 1'b0;
                        state_reg      <= PACK;
                    end
                end

                PACK: begin
                    if (accept) begin
                        // A clear_sign coinciding with a byte is deferred a cycle.
                        if (i_clear_sign) begin
                            clear_pend_reg <= 1'b1;
                        end
                        if (pk_count == 3'd3) begin
                            wr_valid_reg <= 1'b1;
                            state_reg    <= WRITE;
                        end
                    end else if (i_clear_sign || clear_pend_reg) begin
                        clear_pend_reg <= 1'b0;
                        if (pk_count == 3'd0) begin
                            load_done_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            wr_valid_reg <= 1'b1;
                            state_reg    <= FLUSH;
                        end
                    end
                end

                WRITE: begin
                    // Timeout seen while stalled is remembered for PACK.
                    if (i_clear_sign) begin
                        clear_pend_reg <= 1'b1;
                    end
                    if (handshake) begin
                        wr_valid_reg   <= 1'b0;
                        wr_addr_reg    <= wr_addr_reg + ADDR_ONE;
                        word_count_reg <= word_count_reg + CNT_ONE;
                        if (wr_addr_reg == '1) begin
                            addr_wrap_reg <= 1'b1;
                        end
                        skid_full_reg  <= 1'b0;
                        state_reg      <= PACK;
                    end else if (accept && !skid_full_reg) begin
                        skid_reg      <= i_data;
                        skid_full_reg <= 1'b1;
                    end
                end

                FLUSH: begin
                    if (handshake) begin
                        wr_valid_reg   <= 1'b0;
                        wr_addr_reg    <= wr_addr_reg + ADDR_ONE;
                        word_count_reg <= word_count_reg + CNT_ONE;
                        if (wr_addr_reg == '1) begin
                            addr_wrap_reg <= 1'b1;
                        end
                        load_done_reg  <= 1'b1;
                        state_reg      <= DONE;
                    end
                end

                DONE: begin
                    load_done_reg <= 1'b0;
                    state_reg     <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum_reg;

    always_ff @(posedge i_clk_uart or posedge i_rst) begin
        if (i_rst) begin
            checksum_reg <= 8'h00;
        end else if ((state_reg == IDLE) && accept) begin
            checksum_reg <= i_data;
        end else if (byte_taken) begin
            checksum_reg <= checksum_reg ^ i_data;
        end
    end

    assign o_checksum = checksum_reg;
`endif

    assign o_wr_valid   = wr_valid_reg;
    assign o_wr_addr    = wr_addr_reg;
    assign o_wr_data    = pk_word;
    assign o_load_done  = load_done_reg;
    assign o_word_count = word_count_reg;
    assign o_overrun    = overrun_reg;
    assign o_addr_wrap  = addr_wrap_reg;

endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader -- directed bench for uart_word_loader.
// Three instances share one stimulus stream: default (MSB first, 10-bit
// address), LSB first, and a 2-bit address build for the wrap case.
module tb_uart_word_loader;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       clear;
    logic       wr_ready;

    logic        m_wr_valid, l_wr_valid, w_wr_valid;
    logic [9:0]  m_wr_addr,  l_wr_addr;
    logic [1:0]  w_wr_addr;
    logic [31:0] m_wr_data,  l_wr_data,  w_wr_data;
    logic        m_done,     l_done,     w_done;
    logic [10:0] m_count,    l_count;
    logic [2:0]  w_count;
    logic        m_ovr,      l_ovr,      w_ovr;
    logic        m_wrap,     l_wrap,     w_wrap;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  m_csum, l_csum, w_csum;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] qm_data[$], ql_data[$], qw_data[$];
    int          qm_addr[$], ql_addr[$], qw_addr[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_word_loader u_msb (
        .i_clk_uart (clk), .i_rst (rst), .i_data (data), .i_valid (valid),
        .i_clear_sign (clear), .i_wr_ready (wr_ready),
        .o_wr_valid (m_wr_valid), .o_wr_addr (m_wr_addr), .o_wr_data (m_wr_data),
        .o_load_done (m_done), .o_word_count (m_count),
        .o_overrun (m_ovr), .o_addr_wrap (m_wrap)
`ifdef LOADER_CHECKSUM_EN
        , .o_checksum (m_csum)
`endif
    );

    uart_word_loader #(.MSB_FIRST(1'b0)) u_lsb (
        .i_clk_uart (clk), .i_rst (rst), .i_data (data), .i_valid (valid),
        .i_clear_sign (clear), .i_wr_ready (wr_ready),
        .o_wr_valid (l_wr_valid), .o_wr_addr (l_wr_addr), .o_wr_data (l_wr_data),
        .o_load_done (l_done), .o_word_count (l_count),
        .o_overrun (l_ovr), .o_addr_wrap (l_wrap)
`ifdef LOADER_CHECKSUM_EN
        , .o_checksum (l_csum)
`endif
    );

    uart_word_loader #(.ADDR_WIDTH(2)) u_w2 (
        .i_clk_uart (clk), .i_rst (rst), .i_data (data), .i_valid (valid),
        .i_clear_sign (clear), .i_wr_ready (wr_ready),
        .o_wr_valid (w_wr_valid), .o_wr_addr (w_wr_addr), .o_wr_data (w_wr_data),
        .o_load_done (w_done), .o_word_count (w_count),
        .o_overrun (w_ovr), .o_addr_wrap (w_wrap)
`ifdef LOADER_CHECKSUM_EN
        , .o_checksum (w_csum)
`endif
    );

    // Write loggers: one line per completed write.
    always @(posedge clk) begin
        if (!rst && m_wr_valid && wr_ready) begin
            qm_addr.push_back(int'(m_wr_addr));
            qm_data.push_back(m_wr_data);
            $display("[%0t] msb write addr=%0d data=%h", $time, m_wr_addr, m_wr_data);
        end
        if (!rst && l_wr_valid && wr_ready) begin
            ql_addr.push_back(int'(l_wr_addr));
            ql_data.push_back(l_wr_data);
            $display("[%0t] lsb write addr=%0d data=%h", $time, l_wr_addr, l_wr_data);
        end
        if (!rst && w_wr_valid && wr_ready) begin
            qw_addr.push_back(int'(w_wr_addr));
            qw_data.push_back(w_wr_data);
            $display("[%0t] w2  write addr=%0d data=%h", $time, w_wr_addr, w_wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Pulse clear_sign for one cycle and count load_done cycles over a window.
    task automatic do_clear(output int pulses);
        pulses = 0;
        @(negedge clk);
        clear = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) clear = 1'b0;
            if (m_done) pulses++;
        end
    endtask

    task automatic clear_queues();
        qm_addr.delete(); qm_data.delete();
        ql_addr.delete(); ql_data.delete();
        qw_addr.delete(); qw_data.delete();
    endtask

    function automatic logic [31:0] qd(input logic [31:0] q[$], input int k);
        return (q.size() > k) ? q[k] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qa(input int q[$], input int k);
        return (q.size() > k) ? 32'(q[k]) : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int unstable;

        rst = 1'b1; data = 8'h00; valid = 1'b0; clear = 1'b0; wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_wr_valid",  32'(m_wr_valid), 32'd0);
        check("rst_wr_addr",   32'(m_wr_addr),  32'd0);
        check("rst_wr_data",   m_wr_data,       32'd0);
        check("rst_load_done", 32'(m_done),     32'd0);
        check("rst_count",     32'(m_count),    32'd0);
        check("rst_overrun",   32'(m_ovr),      32'd0);
        check("rst_wrap",      32'(m_wrap),     32'd0);

        // 1: one full word, MSB first, then timeout
        clear_queues();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        do_clear(pulses);
        check("s1_nwrites",  32'(qm_data.size()), 32'd1);
        check("s1_addr",     qa(qm_addr, 0), 32'd0);
        check("s1_data",     qd(qm_data, 0), 32'h12345678);
        check("s1_lsb_data", qd(ql_data, 0), 32'h78563412);
        check("s1_done_pulse", 32'(pulses), 32'd1);
        check("s1_count",    32'(m_count), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        check("s1_checksum", 32'(m_csum), 32'h08);
`endif

        // 2: six bytes, LSB first, flushed partial word
        clear_queues();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'hDD); send_byte(8'hEE); send_byte(8'hFF);
        do_clear(pulses);
        check("s2_nwrites", 32'(ql_data.size()), 32'd2);
        check("s2_addr0",   qa(ql_addr, 0), 32'd0);
        check("s2_data0",   qd(ql_data, 0), 32'hDDCCBBAA);
        check("s2_addr1",   qa(ql_addr, 1), 32'd1);
        check("s2_data1",   qd(ql_data, 1), 32'h0000FFEE);
        check("s2_count",   32'(l_count), 32'd2);
        check("s2_msb_pad", qd(qm_data, 1), 32'hEEFF0000);
        check("s2_done_pulse", 32'(pulses), 32'd1);

        // 3: valid held high for 10 cycles counts as one byte
        clear_queues();
        @(negedge clk);
        data = 8'h5A; valid = 1'b1;
        repeat (10) @(negedge clk);
        valid = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        do_clear(pulses);
        check("s3_nwrites", 32'(qm_data.size()), 32'd1);
        check("s3_data",    qd(qm_data, 0), 32'h5A010203);
        check("s3_count",   32'(m_count), 32'd1);

        // 4: stalled write, one byte to skid, one dropped
        clear_queues();
        wr_ready = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_wr_valid !== 1'b1 || m_wr_addr !== 10'd0 || m_wr_data !== 32'h11223344)
                unstable++;
            if (i == 2)  begin data = 8'h55; valid = 1'b1; end
            if (i == 3)  valid = 1'b0;
            if (i == 6)  begin data = 8'h66; valid = 1'b1; end
            if (i == 7)  valid = 1'b0;
        end
        check("s4_stable_cycles_bad", 32'(unstable), 32'd0);
        check("s4_overrun",  32'(m_ovr), 32'd1);
        check("s4_nwrites_stalled", 32'(qm_data.size()), 32'd0);
        wr_ready = 1'b1;
        send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
        do_clear(pulses);
        check("s4_nwrites", 32'(qm_data.size()), 32'd2);
        check("s4_data0",   qd(qm_data, 0), 32'h11223344);
        check("s4_addr1",   qa(qm_addr, 1), 32'd1);
        check("s4_data1",   qd(qm_data, 1), 32'h55778899);
        check("s4_count",   32'(m_count), 32'd2);
        check("s4_overrun_sticky", 32'(m_ovr), 32'd1);

        // 5: 2-bit address, five words wrap to address 0
        clear_queues();
        check("s5_wrap_before", 32'(w_wrap), 32'd0);
        for (int k = 0; k < 20; k++) send_byte(8'(8'h10 + k));
        do_clear(pulses);
        check("s5_nwrites", 32'(qw_data.size()), 32'd5);
        check("s5_addr3",   qa(qw_addr, 3), 32'd3);
        check("s5_addr4",   qa(qw_addr, 4), 32'd0);
        check("s5_data4",   qd(qw_data, 4), 32'h20212223);
        check("s5_wrap",    32'(w_wrap), 32'd1);
        check("s5_count",   32'(w_count), 32'd5);
        check("s5_msb_nowrap", 32'(m_wrap), 32'd0);
        check("s5_msb_addr4",  qa(qm_addr, 4), 32'd4);

        // 6: reset mid-session discards the partial word
        clear_queues();
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s6_wr_valid", 32'(m_wr_valid), 32'd0);
        check("s6_wr_addr",  32'(m_wr_addr),  32'd0);
        check("s6_wr_data",  m_wr_data,       32'd0);
        check("s6_count",    32'(m_count),    32'd0);
        check("s6_overrun",  32'(m_ovr),      32'd0);
        check("s6_wrap_w2",  32'(w_wrap),     32'd0);
        check("s6_done",     32'(m_done),     32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("s6_nwrites_rst", 32'(qm_data.size()), 32'd0);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        do_clear(pulses);
        check("s6_nwrites", 32'(qm_data.size()), 32'd1);
        check("s6_addr",    qa(qm_addr, 0), 32'd0);
        check("s6_data",    qd(qm_data, 0), 32'hA1A2A3A4);
        check("s6_count_after", 32'(m_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
